pybit_seq_gen: RTL

- Parametrised payload bit sequencer/word packer. Successor to the single-mode payload bit counter in the baseband datapath.
- Sequences payload, CRC16 and FEC1/3 / FEC2/3 slots for TX and RX with one common timing engine.
- In RX it packs decoded bits into WORD_W-bit words for the payload RAM, with addressing and an overflow guard.
- It also generates the EDR trailer window.
- Sits between the packet-level controller (py_st_p, length, coding flags) and the FEC/whitening/CRC pipe.

---
 rtl/pybit_seq_gen_if.sv | 25 ++
 rtl/pybit_seq_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pybit_seq_gen_if.sv
// RX word write bus between the payload bit sequencer and the payload RAM.
// The master drives the packed word, its write strobe/address and overflow.
interface pybit_seq_gen_if #(
  parameter int WORD_W = 32,
  parameter int ADR_W  = 8
);
  logic [WORD_W-1:0] rxword;
  logic              rxword_valid_p;
  logic [ADR_W-1:0]  rxword_adr;
  logic              rx_overflow;

  modport master (
    output rxword,
    output rxword_valid_p,
    output rxword_adr,
    output rx_overflow
  );

  modport slave (
    input rxword,
    input rxword_valid_p,
    input rxword_adr,
    input rx_overflow
  );
endinterface

// File: rtl/pybit_seq_gen.sv
// Payload bit sequencer: payload/CRC/FEC slot timing, EDR trailer window
// and RX word packing with address generation and an overflow guard.
module pybit_seq_gen #(
  parameter int WORD_W     = 32,
  parameter int ADR_W      = 8,
  parameter int DEPTH      = 256,
  parameter int TRAIL_DPSK = 4,
  parameter int TRAIL_8PSK = 6
) (
  input  logic        clk_6M,
  input  logic        rstz,
  input  logic        py_st_p,
  input  logic        abort_p,
  input  logic        py_datvalid_p,
  input  logic [12:0] pylenbit,
  input  logic        crcencode,
  input  logic        fec31encode,
  input  logic        fec32encode,
  input  logic        packet_BRmode,
  input  logic        packet_DPSK,
  input  logic        rx_mode,
  input  logic        rxbit_dec,
  output logic        py_period,
  output logic        daten,
  output logic        fec32en,
  output logic [12:0] pybitcount,
  output logic        py_datperiod,
  output logic        py_crcperiod,
  output logic        py_endp,
  output logic        edrtailer,
  output logic        edrtailer_endp,
  pybit_seq_gen_if.master rxw
);

  localparam int CW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PY,
    S_TRL
  } state_e;

  state_e            state_q;
  logic [3:0]        blk_cnt_q;
  logic [1:0]        rep_cnt_q;
  logic [12:0]       pybitcount_q;
  logic [3:0]        trl_cnt_q;
  logic [WORD_W-1:0] sh_q;
  logic [CW-1:0]     cnt_q;
  logic [WORD_W-1:0] word_q;
  logic              valid_q;
  logic [ADR_W:0]    adr_q;
  logic              ovf_q;

  logic [13:0]       sum;
  logic [12:0]       totlen;
  logic              m32;
  logic              m31;
  logic              stb;
  logic              slot_info;
  logic              last_bit;
  logic              end_slot;
  logic              inc;
  logic              take;
  logic [WORD_W-1:0] nsh;
  logic [CW-1:0]     ncnt;
  logic [CW-1:0]     shamt;
  logic              full;
  logic              flush;
  logic              wr;
  logic [WORD_W-1:0] wword;
  logic              trl_stb;
  logic [3:0]        tlast;

  assign sum    = {1'b0, pylenbit} + (crcencode ? 14'd16 : 14'd0);
  assign totlen = sum[13] ? 13'h1fff : sum[12:0];

  // fec32encode outranks fec31encode
  assign m32 = fec32encode;
  assign m31 = ~fec32encode & fec31encode;

  assign stb       = (state_q == S_PY) & py_datvalid_p;
  assign slot_info = m32 ? (blk_cnt_q < 4'd10) : 1'b1;
  assign daten     = stb & slot_info;
  assign fec32en   = stb & m32 & ~slot_info;
  assign last_bit  = pybitcount_q == (totlen - 13'd1);

  always_comb begin
    end_slot = last_bit;
    unique case (1'b1)
      m32:     end_slot = (blk_cnt_q == 4'd14) & (pybitcount_q >= totlen);
      m31:     end_slot = (rep_cnt_q == 2'd2) & last_bit;
      default: end_slot = last_bit;
    endcase
  end

  assign py_endp = stb & end_slot;

  always_comb begin
    inc = stb;
    unique case (1'b1)
      m32:     inc = daten;
      m31:     inc = stb & (rep_cnt_q == 2'd2);
      default: inc = stb;
    endcase
  end

  // Pad slots past totlen are never packed
  assign take  = rx_mode & inc & (pybitcount_q < totlen);
  assign nsh   = take ? {rxbit_dec, sh_q[WORD_W-1:1]} : sh_q;
  assign ncnt  = cnt_q + CW'(take);
  assign shamt = CW'(WORD_W) - ncnt;
  assign full  = ncnt == CW'(WORD_W);
  assign flush = py_endp & (ncnt != '0) & ~full;
  assign wr    = full | flush;
  assign wword = full ? nsh : (nsh >> shamt);

  assign tlast   = packet_DPSK ? 4'(TRAIL_DPSK - 1) : 4'(TRAIL_8PSK - 1);
  assign trl_stb = (state_q == S_TRL) & py_datvalid_p;
  assign edrtailer_endp = trl_stb & (trl_cnt_q == tlast);

  assign py_period    = state_q == S_PY;
  assign edrtailer    = state_q == S_TRL;
  assign pybitcount   = pybitcount_q;
  assign py_datperiod = py_period & (pybitcount_q < pylenbit);
  assign py_crcperiod = py_period & (pybitcount_q >= pylenbit) & crcencode;

  assign rxw.rxword         = word_q;
  assign rxw.rxword_valid_p = valid_q;
  assign rxw.rxword_adr     = adr_q[ADR_W-1:0];
  assign rxw.rx_overflow    = ovf_q;

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state_q      <= S_IDLE;
      blk_cnt_q    <= '0;
      rep_cnt_q    <= '0;
      pybitcount_q <= '0;
      trl_cnt_q    <= '0;
      sh_q         <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      valid_q      <= 1'b0;
      adr_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (valid_q) adr_q <= adr_q + 1'b1;
      if (abort_p) begin
        state_q <= S_IDLE;
        sh_q    <= '0;
        cnt_q   <= '0;
      end else if (py_st_p && totlen != 13'd0) begin
        state_q      <= S_PY;
        blk_cnt_q    <= '0;
        rep_cnt_q    <= '0;
        pybitcount_q <= '0;
        trl_cnt_q    <= '0;
        sh_q         <= '0;
        cnt_q        <= '0;
        adr_q        <= '0;
        ovf_q        <= 1'b0;
      end else begin
        unique case (state_q)
          S_PY: begin
            if (stb) begin
              blk_cnt_q    <= (blk_cnt_q == 4'd14) ? 4'd0 : blk_cnt_q + 4'd1;
              rep_cnt_q    <= (rep_cnt_q == 2'd2) ? 2'd0 : rep_cnt_q + 2'd1;
              pybitcount_q <= pybitcount_q + 13'(inc);
              if (py_endp) begin
                state_q   <= packet_BRmode ? S_IDLE : S_TRL;
                trl_cnt_q <= '0;
              end
            end
          end
          S_TRL: begin
            if (trl_stb) begin
              if (edrtailer_endp) state_q <= S_IDLE;
              else trl_cnt_q <= trl_cnt_q + 4'd1;
            end
          end
          default: ;
        endcase
        sh_q  <= wr ? '0 : nsh;
        cnt_q <= wr ? '0 : ncnt;
        // A full buffer drops the word and latches the overflow flag
        if (wr) begin
          if (adr_q == (ADR_W + 1)'(DEPTH)) begin
            ovf_q <= 1'b1;
          end else begin
            valid_q <= 1'b1;
            word_q  <= wword;
          end
        end
      end
    end
  end

endmodule
